// File: rtl/note_track_engine.sv
// ---------------------------------------------------------------------------
// note_track_engine
//
// Gameplay core for a four-lane falling-note rhythm game.  Notes scroll down
// a ROWS-deep grid once every FRAMES_PER_STEP video frames.  Key presses
// are judged against a two-row strike zone at the bottom of each lane.  The
// grid, a BCD score, per-lane hit LEDs and the game state are all exported
// as registered outputs for the display and board I/O stages.
//
// Ports:
//   clk         pixel-domain clock
//   rst_n       asynchronous active-low reset
//   start       level, high = run game (asynchronous, synchronized here)
//   frame_tick  one-cycle pulse per video frame
//   lane_key    raw active-high lane buttons (asynchronous, synchronized here)
//   note_map    note present, bit index = lane*ROWS + row (row 0 = top)
//   score_bcd   four BCD digits, [15:12] = thousands, saturates at 9999
//   miss_count  misses this game, saturates at 255
//   hit_led     bit i set after a hit in lane i, cleared on each scroll step
//   game_state  0 = IDLE, 1 = PLAY, 2 = OVER
// ---------------------------------------------------------------------------
module note_track_engine #(
    parameter int          ROWS            = 16,
    parameter int          FRAMES_PER_STEP = 8,
    parameter int          MAX_MISS        = 10,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              frame_tick,
    input  logic [3:0]        lane_key,
    output logic [4*ROWS-1:0] note_map,
    output logic [15:0]       score_bcd,
    output logic [7:0]        miss_count,
    output logic [3:0]        hit_led,
    output logic [1:0]        game_state
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                start_s1_q, start_s1_d;
    logic                start_s2_q, start_s2_d;
    logic                start_prev_q, start_prev_d;
    logic [3:0]          key_s1_q, key_s1_d;
    logic [3:0]          key_s2_q, key_s2_d;
    logic [3:0]          key_prev_q, key_prev_d;
    logic [4*ROWS-1:0]   note_q, note_d;
    logic [15:0]         score_q, score_d;
    logic [7:0]          miss_q, miss_d;
    logic [3:0]          hit_led_q, hit_led_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;

    logic                start_rise;
    logic [3:0]          key_press;
    logic [4*ROWS-1:0]   work_map;
    logic [3:0]          hit_vec;
    logic [2:0]          hit_cnt;
    logic [2:0]          miss_add;
    logic [8:0]          miss_sum;
    logic                step;

    assign start_rise = start_s2_q & ~start_prev_q;
    assign key_press  = key_s2_q & ~key_prev_q;

    // Adds 0..4 to a four-digit BCD value; a carry out of the thousands
    // digit means the true sum passed 9999, so the result pins at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [2:0] n);
        logic [15:0] r;
        logic [4:0]  d;
        logic [4:0]  c;
        r = '0;
        c = {2'b00, n};
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + c;
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c = 5'd1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 5'd0;
            end
        end
        if (c != 5'd0) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        start_s1_d   = start;
        start_s2_d   = start_s1_q;
        start_prev_d = start_s2_q;
        key_s1_d     = lane_key;
        key_s2_d     = key_s1_q;
        key_prev_d   = key_s2_q;
        note_d       = note_q;
        score_d      = score_q;
        miss_d       = miss_q;
        hit_led_d    = hit_led_q;
        frame_cnt_d  = frame_cnt_q;
        lfsr_d       = lfsr_q;
        work_map     = note_q;
        hit_vec      = 4'b0000;
        hit_cnt      = 3'd0;
        miss_add     = 3'd0;
        miss_sum     = {1'b0, miss_q};
        step         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d     = ST_PLAY;
                    note_d      = '0;
                    score_d     = '0;
                    miss_d      = '0;
                    hit_led_d   = '0;
                    frame_cnt_d = '0;
                    lfsr_d      = LFSR_SEED;
                end
            end

            ST_PLAY: begin
                if (!start_s2_q) begin
                    state_d = ST_IDLE;
                    note_d  = '0;
                end else begin
                    // Judge presses on the pre-step map so that a struck note
                    // is gone before the shift and can never count as a miss.
                    for (int lane = 0; lane < 4; lane++) begin
                        if (key_press[lane]) begin
                            if (work_map[lane*ROWS + ROWS-1]) begin
                                work_map[lane*ROWS + ROWS-1] = 1'b0;
                                hit_vec[lane] = 1'b1;
                            end else if (work_map[lane*ROWS + ROWS-2]) begin
                                work_map[lane*ROWS + ROWS-2] = 1'b0;
                                hit_vec[lane] = 1'b1;
                            end
                        end
                        hit_cnt = hit_cnt + {2'b00, hit_vec[lane]};
                    end

                    if (frame_tick) begin
                        if (frame_cnt_q == FC_W'(FRAMES_PER_STEP-1)) begin
                            step        = 1'b1;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_W'(1);
                        end
                    end

                    // A step drops every lane by one row and feeds row 0 from
                    // a two-bit slice of the generator before advancing it.
                    if (step) begin
                        for (int lane = 0; lane < 4; lane++) begin
                            miss_add = miss_add + {2'b00, work_map[lane*ROWS + ROWS-1]};
                            work_map[lane*ROWS +: ROWS] =
                                {work_map[lane*ROWS +: ROWS-1], (lfsr_q[2*lane +: 2] == 2'b00)};
                        end
                        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                    end

                    miss_sum  = {1'b0, miss_q} + {6'b000000, miss_add};
                    miss_d    = miss_sum[8] ? 8'hFF : miss_sum[7:0];
                    note_d    = work_map;
                    score_d   = bcd_add_sat(score_q, hit_cnt);
                    hit_led_d = (step ? 4'b0000 : hit_led_q) | hit_vec;

                    if (step && (miss_d >= 8'(MAX_MISS))) begin
                        state_d = ST_OVER;
                    end
                end
            end

            ST_OVER: begin
                if (!start_s2_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            key_s1_q     <= '0;
            key_s2_q     <= '0;
            key_prev_q   <= '0;
            note_q       <= '0;
            score_q      <= '0;
            miss_q       <= '0;
            hit_led_q    <= '0;
            frame_cnt_q  <= '0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            state_q      <= state_d;
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_prev_q <= start_prev_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            key_prev_q   <= key_prev_d;
            note_q       <= note_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            hit_led_q    <= hit_led_d;
            frame_cnt_q  <= frame_cnt_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign note_map   = note_q;
    assign score_bcd  = score_q;
    assign miss_count = miss_q;
    assign hit_led    = hit_led_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_note_track_engine.sv
// ---------------------------------------------------------------------------
// tb_note_track_engine
//
// Drives note_track_engine with directed and randomized stimulus and checks
// every output against a behavioural game model kept in this file.  The
// model tracks the grid as a lane/row array, the score as a plain integer
// and the generator as an integer shift, applied once per clock edge.
// ---------------------------------------------------------------------------
module tb_note_track_engine;

    localparam int ROWS     = 16;
    localparam int FPS      = 2;
    localparam int MAX_MISS = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              frame_tick;
    logic [3:0]        lane_key;
    logic [4*ROWS-1:0] note_map;
    logic [15:0]       score_bcd;
    logic [7:0]        miss_count;
    logic [3:0]        hit_led;
    logic [1:0]        game_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int          m_state;
    bit          m_note [4][ROWS];
    int          m_score;
    int          m_miss;
    int          m_fc;
    int          m_steps;
    bit [3:0]    m_hit;
    int unsigned m_lfsr;
    bit [3:0]    k_hist [3];
    bit          st_hist [3];

    note_track_engine #(
        .ROWS            (ROWS),
        .FRAMES_PER_STEP (FPS),
        .MAX_MISS        (MAX_MISS),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .lane_key   (lane_key),
        .note_map   (note_map),
        .score_bcd  (score_bcd),
        .miss_count (miss_count),
        .hit_led    (hit_led),
        .game_state (game_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [4*ROWS-1:0] exp_map();
        logic [4*ROWS-1:0] v;
        v = '0;
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < ROWS; r++)
                v[l*ROWS + r] = m_note[l][r];
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_score = 0;
        m_miss  = 0;
        m_fc    = 0;
        m_steps = 0;
        m_hit   = 4'b0;
        m_lfsr  = 32'hACE1;
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < ROWS; r++)
                m_note[l][r] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            k_hist[i]  = 4'b0;
            st_hist[i] = 1'b0;
        end
    endtask

    // One clock edge of game rules.  Inputs reach the game logic two edges
    // after they are sampled, so presses and start edges come from history.
    task automatic model_edge();
        bit [3:0]    press;
        bit [3:0]    hits;
        bit          s_lvl;
        bit          s_rise;
        bit          stepping;
        int          nhit;
        int          nmiss;
        int unsigned fb;
        press    = k_hist[1] & ~k_hist[2];
        s_lvl    = st_hist[1];
        s_rise   = st_hist[1] & ~st_hist[2];
        hits     = 4'b0;
        nhit     = 0;
        nmiss    = 0;
        stepping = 1'b0;
        case (m_state)
            0: begin
                if (s_rise) begin
                    m_state = 1;
                    m_score = 0;
                    m_miss  = 0;
                    m_fc    = 0;
                    m_hit   = 4'b0;
                    m_lfsr  = 32'hACE1;
                    for (int l = 0; l < 4; l++)
                        for (int r = 0; r < ROWS; r++)
                            m_note[l][r] = 1'b0;
                end
            end
            1: begin
                if (!s_lvl) begin
                    m_state = 0;
                    for (int l = 0; l < 4; l++)
                        for (int r = 0; r < ROWS; r++)
                            m_note[l][r] = 1'b0;
                end else begin
                    for (int l = 0; l < 4; l++) begin
                        if (press[l]) begin
                            if (m_note[l][ROWS-1]) begin
                                m_note[l][ROWS-1] = 1'b0;
                                hits[l] = 1'b1;
                                nhit++;
                            end else if (m_note[l][ROWS-2]) begin
                                m_note[l][ROWS-2] = 1'b0;
                                hits[l] = 1'b1;
                                nhit++;
                            end
                        end
                    end
                    if (frame_tick) begin
                        if (m_fc == FPS - 1) begin
                            stepping = 1'b1;
                            m_fc = 0;
                        end else begin
                            m_fc++;
                        end
                    end
                    if (stepping) begin
                        m_steps++;
                        for (int l = 0; l < 4; l++) begin
                            if (m_note[l][ROWS-1]) nmiss++;
                            for (int r = ROWS - 1; r > 0; r--)
                                m_note[l][r] = m_note[l][r-1];
                            m_note[l][0] = (((m_lfsr >> (2*l)) & 3) == 0);
                        end
                        fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
                        m_lfsr = (m_lfsr >> 1) | (fb << 15);
                    end
                    m_score = (m_score + nhit > 9999) ? 9999 : m_score + nhit;
                    m_miss  = (m_miss + nmiss > 255) ? 255 : m_miss + nmiss;
                    m_hit   = (stepping ? 4'b0 : m_hit) | hits;
                    if (stepping && m_miss >= MAX_MISS) m_state = 2;
                end
            end
            default: begin
                if (!s_lvl) m_state = 0;
            end
        endcase
        k_hist[2]  = k_hist[1];
        k_hist[1]  = k_hist[0];
        k_hist[0]  = lane_key;
        st_hist[2] = st_hist[1];
        st_hist[1] = st_hist[0];
        st_hist[0] = start;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_step();
        int s0;
        s0 = m_steps;
        for (int i = 0; i < FPS + 2 && m_steps == s0; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic restart();
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        lane_key   = 4'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10 && m_state != 1; i++) tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        lane_key   = 4'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (note_map !== '0) begin n_bad++; $display("[TB] FAIL reset_map: got %h want 0", note_map); end
        n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_score: got %h want 0000", score_bcd); end
        n_cmp++; if (miss_count !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_miss: got %0d want 0", miss_count); end
        n_cmp++; if (hit_led !== 4'b0) begin n_bad++; $display("[TB] FAIL reset_hitled: got %b want 0000", hit_led); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d want 0", game_state); end
    endtask

    task automatic test_step_lfsr();
        restart();
        n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL enter_play: got %0d want 1", game_state); end
        n_cmp++; if (note_map !== '0) begin n_bad++; $display("[TB] FAIL play_map_clear: got %h want 0", note_map); end
        for (int p = 0; p < 2; p++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        n_cmp++; if (note_map !== 64'h0000_0000_0001_0000) begin n_bad++; $display("[TB] FAIL first_step_row0: got %h want 0000000000010000", note_map); end
        for (int p = 0; p < 2; p++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        n_cmp++; if (note_map !== 64'h0000_0000_0003_0001) begin n_bad++; $display("[TB] FAIL second_step_rows: got %h want 0000000000030001", note_map); end
        n_cmp++; if (note_map !== exp_map()) begin n_bad++; $display("[TB] FAIL step_model_map: got %h want %h", note_map, exp_map()); end
    endtask

    task automatic test_hit_single();
        int lane;
        restart();
        lane = -1;
        for (int s = 0; s < 40 && lane < 0; s++) begin
            do_step();
            for (int l = 0; l < 4; l++)
                if (lane < 0 && m_note[l][ROWS-2] && !m_note[l][ROWS-1]) lane = l;
        end
        n_cmp++;
        if (lane < 0) begin
            n_bad++; $display("[TB] FAIL hit_setup: got no note in zone want one");
        end else begin
            lane_key[lane] = 1'b1; tick(); lane_key = 4'b0;
            repeat (4) tick();
            n_cmp++; if (score_bcd !== 16'h0001) begin n_bad++; $display("[TB] FAIL hit_score: got %h want 0001", score_bcd); end
            n_cmp++; if (hit_led !== 4'(1 << lane)) begin n_bad++; $display("[TB] FAIL hit_led: got %b want %b", hit_led, 4'(1 << lane)); end
            n_cmp++; if (note_map[lane*ROWS + ROWS-2] !== 1'b0) begin n_bad++; $display("[TB] FAIL hit_cleared: got 1 want 0"); end
            n_cmp++; if (note_map !== exp_map()) begin n_bad++; $display("[TB] FAIL hit_map: got %h want %h", note_map, exp_map()); end
            do_step();
            n_cmp++; if (hit_led !== 4'b0) begin n_bad++; $display("[TB] FAIL hitled_clear_on_step: got %b want 0000", hit_led); end
        end
    endtask

    task automatic test_same_cycle_step();
        int lane;
        int other;
        int prior_miss;
        int empty_lane;
        logic [4*ROWS-1:0] snap_map;
        logic [3:0]        snap_hit;
        restart();
        lane = -1;
        for (int s = 0; s < 40 && lane < 0; s++) begin
            do_step();
            for (int l = 0; l < 4; l++)
                if (lane < 0 && m_note[l][ROWS-1]) lane = l;
        end
        n_cmp++;
        if (lane < 0) begin
            n_bad++; $display("[TB] FAIL strike_setup: got no note at bottom want one");
        end else begin
            other = 0;
            for (int l = 0; l < 4; l++)
                if (l != lane && m_note[l][ROWS-1]) other++;
            prior_miss = m_miss;
            lane_key[lane] = 1'b1;
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; lane_key = 4'b0;
            tick();
            n_cmp++; if (score_bcd !== 16'h0001) begin n_bad++; $display("[TB] FAIL strike_score: got %h want 0001", score_bcd); end
            n_cmp++; if (miss_count !== 8'(prior_miss + other)) begin n_bad++; $display("[TB] FAIL strike_no_miss: got %0d want %0d", miss_count, prior_miss + other); end
            n_cmp++; if (hit_led[lane] !== 1'b1) begin n_bad++; $display("[TB] FAIL strike_led: got %b want lane %0d lit", hit_led, lane); end
            n_cmp++; if (note_map !== exp_map()) begin n_bad++; $display("[TB] FAIL strike_map: got %h want %h", note_map, exp_map()); end

            empty_lane = -1;
            for (int l = 0; l < 4; l++)
                if (empty_lane < 0 && !m_note[l][ROWS-1] && !m_note[l][ROWS-2]) empty_lane = l;
            if (empty_lane >= 0) begin
                snap_map = exp_map();
                snap_hit = m_hit;
                lane_key[empty_lane] = 1'b1; tick(); lane_key = 4'b0;
                repeat (5) tick();
                n_cmp++; if (score_bcd !== 16'h0001) begin n_bad++; $display("[TB] FAIL empty_press_score: got %h want 0001", score_bcd); end
                n_cmp++; if (note_map !== snap_map) begin n_bad++; $display("[TB] FAIL empty_press_map: got %h want %h", note_map, snap_map); end
                n_cmp++; if (hit_led !== snap_hit) begin n_bad++; $display("[TB] FAIL empty_press_led: got %b want %b", hit_led, snap_hit); end
            end
        end
    endtask

    task automatic test_multi_lane();
        bit [3:0] mask;
        int       cnt;
        restart();
        mask = 4'b0;
        cnt  = 0;
        for (int s = 0; s < 60 && cnt < 2; s++) begin
            do_step();
            mask = 4'b0;
            cnt  = 0;
            for (int l = 0; l < 4; l++)
                if (m_note[l][ROWS-1] || m_note[l][ROWS-2]) begin mask[l] = 1'b1; cnt++; end
        end
        n_cmp++;
        if (cnt < 2) begin
            n_bad++; $display("[TB] FAIL multi_setup: got %0d lanes in zone want at least 2", cnt);
        end else begin
            lane_key = 4'hF; tick(); lane_key = 4'b0;
            repeat (4) tick();
            n_cmp++; if (score_bcd !== to_bcd(cnt)) begin n_bad++; $display("[TB] FAIL multi_score: got %h want %h", score_bcd, to_bcd(cnt)); end
            n_cmp++; if (hit_led !== mask) begin n_bad++; $display("[TB] FAIL multi_led: got %b want %b", hit_led, mask); end
            n_cmp++; if (note_map !== exp_map()) begin n_bad++; $display("[TB] FAIL multi_map: got %h want %h", note_map, exp_map()); end
        end
    endtask

    task automatic test_game_over();
        logic [4*ROWS-1:0] snap_map;
        int                snap_miss;
        restart();
        for (int s = 0; s < 200 && m_state == 1; s++) do_step();
        tick();
        n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL over_state: got %0d want 2", game_state); end
        n_cmp++; if (miss_count < 8'(MAX_MISS)) begin n_bad++; $display("[TB] FAIL over_miss_min: got %0d want >= %0d", miss_count, MAX_MISS); end
        n_cmp++; if (miss_count !== 8'(m_miss)) begin n_bad++; $display("[TB] FAIL over_miss: got %0d want %0d", miss_count, m_miss); end
        snap_map  = exp_map();
        snap_miss = m_miss;
        for (int p = 0; p < 6; p++) begin
            frame_tick = 1'b1; lane_key = 4'hF; tick();
            frame_tick = 1'b0; lane_key = 4'h0; tick();
        end
        n_cmp++; if (note_map !== snap_map) begin n_bad++; $display("[TB] FAIL over_frozen_map: got %h want %h", note_map, snap_map); end
        n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("[TB] FAIL over_frozen_score: got %h want 0000", score_bcd); end
        n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL over_hold: got %0d want 2", game_state); end
        start = 1'b0;
        repeat (4) tick();
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL over_to_idle: got %0d want 0", game_state); end
        n_cmp++; if (miss_count !== 8'(snap_miss)) begin n_bad++; $display("[TB] FAIL idle_miss_kept: got %0d want %0d", miss_count, snap_miss); end
    endtask

    task automatic test_reset_mid_play();
        restart();
        for (int c = 0; c < 40; c++) begin
            frame_tick = 1'(c % 2);
            lane_key   = 4'($urandom_range(0, 15));
            tick();
        end
        lane_key   = 4'b0;
        frame_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (note_map !== '0) begin n_bad++; $display("[TB] FAIL async_rst_map: got %h want 0", note_map); end
        n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("[TB] FAIL async_rst_score: got %h want 0000", score_bcd); end
        n_cmp++; if (miss_count !== 8'd0) begin n_bad++; $display("[TB] FAIL async_rst_miss: got %0d want 0", miss_count); end
        n_cmp++; if (hit_led !== 4'b0) begin n_bad++; $display("[TB] FAIL async_rst_led: got %b want 0000", hit_led); end
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL async_rst_state: got %0d want 0", game_state); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_start_drop();
        restart();
        for (int c = 0; c < 400 && m_score == 0; c++) begin
            frame_tick = 1'(c % 2);
            lane_key   = (c % 2 == 0) ? 4'hF : 4'h0;
            tick();
        end
        frame_tick = 1'b0;
        lane_key   = 4'b0;
        start      = 1'b0;
        repeat (4) tick();
        n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL drop_state: got %0d want 0", game_state); end
        n_cmp++; if (note_map !== '0) begin n_bad++; $display("[TB] FAIL drop_map: got %h want 0", note_map); end
        n_cmp++; if (m_score == 0 || score_bcd !== to_bcd(m_score)) begin n_bad++; $display("[TB] FAIL drop_score_kept: got %h want %h (nonzero)", score_bcd, to_bcd(m_score)); end
    endtask

    task automatic test_random();
        logic [93:0] got;
        logic [93:0] want;
        restart();
        for (int c = 0; c < 3000; c++) begin
            frame_tick = 1'($urandom_range(0, 1));
            lane_key   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) start = ~start;
            tick();
            got  = {note_map, score_bcd, miss_count, hit_led, game_state};
            want = {exp_map(), to_bcd(m_score), 8'(m_miss), m_hit, 2'(m_state)};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("[TB] FAIL random_cycle_%0d: got %h want %h", c, got, want);
                break;
            end
        end
        frame_tick = 1'b0;
        lane_key   = 4'b0;
    endtask

    // Steady play where every note is struck drives the score across the
    // decimal carries and into the 9999 ceiling.
    task automatic test_marathon();
        int  extra;
        bit  done;
        restart();
        extra = 0;
        done  = 1'b0;
        for (int c = 0; c < 60000 && !done; c++) begin
            frame_tick = (c % 2 == 0);
            lane_key   = (c % 2 == 0) ? 4'hF : 4'h0;
            tick();
            n_cmp++;
            if (score_bcd !== to_bcd(m_score)) begin
                n_bad++;
                $display("[TB] FAIL marathon_score_cycle_%0d: got %h want %h", c, score_bcd, to_bcd(m_score));
                done = 1'b1;
            end
            if (m_score == 9999) extra++;
            if (extra >= 40) done = 1'b1;
        end
        frame_tick = 1'b0;
        lane_key   = 4'b0;
        n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("[TB] FAIL score_saturate: got %h want 9999", score_bcd); end
        n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL marathon_state: got %0d want 1", game_state); end
        n_cmp++; if (miss_count !== 8'(m_miss)) begin n_bad++; $display("[TB] FAIL marathon_miss: got %0d want %0d", miss_count, m_miss); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        lane_key   = 4'b0;
        model_reset();
        test_reset();
        test_step_lfsr();
        test_hit_single();
        test_same_cycle_step();
        test_multi_lane();
        test_game_over();
        test_reset_mid_play();
        test_start_drop();
        test_random();
        test_marathon();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
